sd_cmd_sequencer: RTL and testbench

//  Sequences single SD commands through the CMD-line serial engine on behalf of the host register block.

---
 rtl/sd_cmd_sequencer.sv | 129 ++++++++++++
 tb/tb_sd_cmd_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_sequencer.sv
// Single-command sequencer for the SD CMD-line serial engine: latches a host request,
// issues it to the engine, and reports completion, timeout, abort and response status.
module sd_cmd_sequencer #(
  parameter int unsigned ABORT_RST_CYCLES = 4
) (
  input  logic         sd_clk,
  input  logic         rst,
  input  logic         start_i,
  input  logic [5:0]   cmd_idx_i,
  input  logic [31:0]  cmd_arg_i,
  input  logic [1:0]   resp_type_i,
  input  logic         crc_chk_en_i,
  input  logic         idx_chk_en_i,
  input  logic [15:0]  timeout_i,
  input  logic         abort_i,
  output logic         ser_start_o,
  output logic [1:0]   ser_setting_o,
  output logic [39:0]  ser_cmd_o,
  output logic         ser_rst_o,
  input  logic         ser_finish_i,
  input  logic         ser_crc_ok_i,
  input  logic         ser_index_ok_i,
  input  logic [119:0] ser_response_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [4:0]   status_o,
  output logic [119:0] response_o
);

  localparam int unsigned RstCntW = $clog2(ABORT_RST_CYCLES + 1);
  localparam logic [RstCntW-1:0] RstLast = RstCntW'(ABORT_RST_CYCLES);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StIssue = 3'd1,
    StWait  = 3'd2,
    StCheck = 3'd3,
    StAbort = 3'd4
  } state_e;

  state_e             state_q;
  logic [15:0]        tcnt_q;
  logic [15:0]        tmo_q;
  logic [RstCntW-1:0] rcnt_q;
  logic               crc_en_q;
  logic               idx_en_q;
  logic               with_resp;

  assign with_resp = ser_setting_o[0];

  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      tcnt_q        <= '0;
      tmo_q         <= '0;
      rcnt_q        <= '0;
      crc_en_q      <= 1'b0;
      idx_en_q      <= 1'b0;
      ser_start_o   <= 1'b0;
      ser_setting_o <= '0;
      ser_cmd_o     <= '0;
      ser_rst_o     <= 1'b1;
      busy_o        <= 1'b1;
      done_o        <= 1'b0;
      status_o      <= '0;
      response_o    <= '0;
    end else begin
      ser_start_o <= 1'b0;
      done_o      <= 1'b0;
      case (state_q)
        // CHECK has busy_o low, so it accepts a new request exactly like IDLE.
        StIdle, StCheck: begin
          state_q <= StIdle;
          if (ser_rst_o) begin
            // Post-reset engine recovery hold.
            if (rcnt_q == RstLast) begin
              ser_rst_o <= 1'b0;
              busy_o    <= 1'b0;
            end else begin
              rcnt_q <= rcnt_q + 1'b1;
            end
          end else if (start_i && !busy_o) begin
            ser_cmd_o     <= {2'b01, cmd_idx_i, cmd_arg_i};
            ser_setting_o <= {resp_type_i == 2'b10, resp_type_i != 2'b00};
            crc_en_q      <= crc_chk_en_i;
            idx_en_q      <= idx_chk_en_i;
            tmo_q         <= timeout_i;
            status_o      <= '0;
            busy_o        <= 1'b1;
            state_q       <= StIssue;
          end
        end
        StIssue: begin
          ser_start_o <= 1'b1;
          tcnt_q      <= '0;
          state_q     <= StWait;
        end
        StWait: begin
          if (tcnt_q != 16'hFFFF) tcnt_q <= tcnt_q + 16'd1;
          if (ser_finish_i) begin
            if (with_resp) response_o <= ser_response_i;
            status_o <= {idx_en_q & with_resp & ~ser_index_ok_i,
                         crc_en_q & with_resp & ~ser_crc_ok_i, 3'b001};
            done_o   <= 1'b1;
            busy_o   <= 1'b0;
            state_q  <= StCheck;
          end else if (abort_i || (tmo_q != 16'd0 && tcnt_q == tmo_q - 16'd1)) begin
            status_o  <= abort_i ? 5'b00010 : 5'b00100;
            ser_rst_o <= 1'b1;
            rcnt_q    <= RstCntW'(1);
            state_q   <= StAbort;
          end
        end
        StAbort: begin
          if (rcnt_q == RstLast) begin
            ser_rst_o <= 1'b0;
            done_o    <= 1'b1;
            busy_o    <= 1'b0;
            state_q   <= StIdle;
          end else begin
            rcnt_q <= rcnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Bench for sd_cmd_sequencer: directed scenarios plus randomized commands scored against
// an event-timing model of the request/finish/abort/timeout rules.
module tb_sd_cmd_sequencer;

  logic         sd_clk = 1'b0;
  logic         rst;
  logic         start_i;
  logic [5:0]   cmd_idx_i;
  logic [31:0]  cmd_arg_i;
  logic [1:0]   resp_type_i;
  logic         crc_chk_en_i;
  logic         idx_chk_en_i;
  logic [15:0]  timeout_i;
  logic         abort_i;
  logic         ser_start_o;
  logic [1:0]   ser_setting_o;
  logic [39:0]  ser_cmd_o;
  logic         ser_rst_o;
  logic         ser_finish_i;
  logic         ser_crc_ok_i;
  logic         ser_index_ok_i;
  logic [119:0] ser_response_i;
  logic         busy_o;
  logic         done_o;
  logic [4:0]   status_o;
  logic [119:0] response_o;

  int total = 0;
  int bad   = 0;
  logic [119:0] exp_resp;

  sd_cmd_sequencer #(.ABORT_RST_CYCLES(4)) dut (
    .sd_clk        (sd_clk),
    .rst           (rst),
    .start_i       (start_i),
    .cmd_idx_i     (cmd_idx_i),
    .cmd_arg_i     (cmd_arg_i),
    .resp_type_i   (resp_type_i),
    .crc_chk_en_i  (crc_chk_en_i),
    .idx_chk_en_i  (idx_chk_en_i),
    .timeout_i     (timeout_i),
    .abort_i       (abort_i),
    .ser_start_o   (ser_start_o),
    .ser_setting_o (ser_setting_o),
    .ser_cmd_o     (ser_cmd_o),
    .ser_rst_o     (ser_rst_o),
    .ser_finish_i  (ser_finish_i),
    .ser_crc_ok_i  (ser_crc_ok_i),
    .ser_index_ok_i(ser_index_ok_i),
    .ser_response_i(ser_response_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .status_o      (status_o),
    .response_o    (response_o)
  );

  always #5 sd_clk = ~sd_clk;

  function automatic logic [119:0] rand120();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    return r[119:0];
  endfunction

  task automatic drive_idle();
    start_i        = 1'b0;
    cmd_idx_i      = '0;
    cmd_arg_i      = '0;
    resp_type_i    = '0;
    crc_chk_en_i   = 1'b0;
    idx_chk_en_i   = 1'b0;
    timeout_i      = '0;
    abort_i        = 1'b0;
    ser_finish_i   = 1'b0;
    ser_crc_ok_i   = 1'b0;
    ser_index_ok_i = 1'b0;
    ser_response_i = '0;
  endtask

  // Loop index k counts negedges after start_i is raised; the DUT samples inputs driven at
  // negedge k on the following rising edge, whose effect is observed at negedge k+1.
  task automatic run_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                         input logic [1:0] resp, input logic crc_en, input logic idx_en,
                         input logic [15:0] tmo, input logic crc_ok, input logic idx_ok,
                         input logic [119:0] rsp, input int kf, input int ka,
                         input logic hold);
    logic        wr;
    logic [39:0] ecmd;
    logic [1:0]  eset;
    logic [4:0]  est;
    int ef, ea, et, edone, nrst, k, done_k, starts, start_k, rsts;
    wr   = (resp != 2'b00);
    ecmd = {2'b01, idx, arg};
    eset = {resp == 2'b10, wr};
    ef   = (kf != 0) ? kf + 1 : 1 << 30;
    ea   = (ka != 0) ? ka + 1 : 1 << 30;
    et   = (tmo != 0) ? int'(tmo) + 2 : 1 << 30;
    if (ef <= ea && ef <= et) begin
      edone = ef;
      nrst  = 0;
      est   = {idx_en & wr & ~idx_ok, crc_en & wr & ~crc_ok, 3'b001};
      if (wr) exp_resp = rsp;
    end else if (ea <= et) begin
      edone = ea + 4;
      nrst  = 4;
      est   = 5'b00010;
    end else begin
      edone = et + 4;
      nrst  = 4;
      est   = 5'b00100;
    end

    cmd_idx_i    = idx;
    cmd_arg_i    = arg;
    resp_type_i  = resp;
    crc_chk_en_i = crc_en;
    idx_chk_en_i = idx_en;
    timeout_i    = tmo;
    start_i      = 1'b1;
    k = 0; done_k = 0; starts = 0; start_k = 0; rsts = 0;
    while (done_k == 0 && k < edone + 20) begin
      @(negedge sd_clk);
      k++;
      if (k == 1) start_i = hold;
      if (ser_start_o) begin starts++; start_k = k; end
      if (ser_rst_o) rsts++;
      if (k == 2) begin
        total++;
        if (ser_cmd_o !== ecmd) begin
          bad++; $display("FAIL %s ser_cmd: got %h want %h", tag, ser_cmd_o, ecmd);
        end
        total++;
        if (ser_setting_o !== eset) begin
          bad++; $display("FAIL %s setting: got %b want %b", tag, ser_setting_o, eset);
        end
        total++;
        if (busy_o !== 1'b1) begin
          bad++; $display("FAIL %s busy_in_flight: got %b want 1", tag, busy_o);
        end
      end
      if (done_o === 1'b1) begin
        done_k  = k;
        start_i = 1'b0;
        total++;
        if (busy_o !== 1'b0) begin
          bad++; $display("FAIL %s busy_at_done: got %b want 0", tag, busy_o);
        end
        total++;
        if (status_o !== est) begin
          bad++; $display("FAIL %s status: got %b want %b", tag, status_o, est);
        end
        total++;
        if (response_o !== exp_resp) begin
          bad++; $display("FAIL %s response: got %h want %h", tag, response_o, exp_resp);
        end
      end
      ser_finish_i   = (k == kf);
      abort_i        = (k == ka);
      ser_crc_ok_i   = (k == kf) ? crc_ok : 1'($urandom());
      ser_index_ok_i = (k == kf) ? idx_ok : 1'($urandom());
      ser_response_i = (k == kf) ? rsp : rand120();
    end
    start_i      = 1'b0;
    ser_finish_i = 1'b0;
    abort_i      = 1'b0;
    total++;
    if (done_k != edone) begin
      bad++; $display("FAIL %s done_cycle: got %0d want %0d", tag, done_k, edone);
    end
    total++;
    if (starts != 1 || start_k != 2) begin
      bad++; $display("FAIL %s ser_start: got %0d pulses at %0d want 1 at 2", tag, starts,
                      start_k);
    end
    total++;
    if (rsts != nrst) begin
      bad++; $display("FAIL %s ser_rst_cycles: got %0d want %0d", tag, rsts, nrst);
    end
    @(negedge sd_clk);
    total++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++; $display("FAIL %s after_done: got done=%b busy=%b want 0 0", tag, done_o, busy_o);
    end
    total++;
    if (status_o !== est || ser_cmd_o !== ecmd) begin
      bad++; $display("FAIL %s sticky: got %b/%h want %b/%h", tag, status_o, ser_cmd_o, est,
                      ecmd);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    exp_resp = '0;
    repeat (2) @(negedge sd_clk);
    total++;
    if (ser_rst_o !== 1'b1 || done_o !== 1'b0 || ser_start_o !== 1'b0 || status_o !== 5'b0 ||
        response_o !== 120'b0 || ser_cmd_o !== 40'b0 || ser_setting_o !== 2'b0) begin
      bad++; $display("FAIL reset_values: got rst=%b done=%b start=%b status=%b cmd=%h want 1 0 0 0 0",
                      ser_rst_o, done_o, ser_start_o, status_o, ser_cmd_o);
    end
    rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge sd_clk);
      total++;
      if (ser_rst_o !== (k <= 4) || busy_o !== (k <= 4) || done_o !== 1'b0) begin
        bad++; $display("FAIL reset_hold[%0d]: got rst=%b busy=%b done=%b want %b %b 0", k,
                        ser_rst_o, busy_o, done_o, k <= 4, k <= 4);
      end
    end
  endtask

  task automatic test_no_resp();
    run_cmd("no_resp", 6'd0, 32'h0, 2'b00, 1'b1, 1'b1, 16'd0, 1'b0, 1'b0, rand120(), 52, 0,
            1'b0);
  endtask

  task automatic test_short_resp();
    run_cmd("short_resp", 6'd17, 32'h0000_0200, 2'b01, 1'b1, 1'b1, 16'd0, 1'b1, 1'b1,
            120'hA5, 12, 0, 1'b0);
    total++;
    if (ser_cmd_o !== 40'h51_0000_0200 || response_o !== 120'hA5) begin
      bad++; $display("FAIL short_resp_const: got %h/%h want 5100000200/a5", ser_cmd_o,
                      response_o);
    end
  endtask

  task automatic test_long_checks();
    run_cmd("long_err", 6'd2, 32'h1234_5678, 2'b10, 1'b1, 1'b1, 16'd0, 1'b0, 1'b0, rand120(),
            20, 0, 1'b0);
    run_cmd("long_noen", 6'd2, 32'h1234_5678, 2'b10, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, rand120(),
            20, 0, 1'b0);
    run_cmd("type3_err", 6'd9, 32'hCAFE_0001, 2'b11, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, rand120(),
            7, 0, 1'b0);
  endtask

  task automatic test_timeout();
    run_cmd("timeout", 6'd5, 32'h0, 2'b01, 1'b1, 1'b1, 16'd100, 1'b1, 1'b1, rand120(), 0, 0,
            1'b0);
    run_cmd("timeout_one", 6'd5, 32'h1, 2'b00, 1'b0, 1'b0, 16'd1, 1'b1, 1'b1, rand120(), 0, 0,
            1'b0);
  endtask

  task automatic test_abort();
    run_cmd("abort_finish_tie", 6'd8, 32'hABCD, 2'b01, 1'b1, 1'b1, 16'd0, 1'b1, 1'b1,
            rand120(), 20, 20, 1'b0);
    run_cmd("abort_alone", 6'd8, 32'hABCD, 2'b01, 1'b1, 1'b1, 16'd0, 1'b1, 1'b1, rand120(), 0,
            15, 1'b0);
    run_cmd("finish_in_abort", 6'd8, 32'hABCD, 2'b01, 1'b1, 1'b1, 16'd0, 1'b1, 1'b1,
            rand120(), 17, 15, 1'b0);
  endtask

  task automatic test_hold_start();
    run_cmd("hold_start", 6'd3, 32'h55AA_55AA, 2'b01, 1'b0, 1'b0, 16'd0, 1'b1, 1'b1,
            rand120(), 30, 0, 1'b1);
  endtask

  task automatic test_random();
    int kf, ka;
    logic [15:0] tmo;
    for (int i = 0; i < 40; i++) begin
      tmo = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 60));
      kf  = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(2, 70));
      ka  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 70)) : 0;
      if (tmo == 0 && kf == 0 && ka == 0) kf = int'($urandom_range(2, 70));
      run_cmd($sformatf("rand%0d", i), 6'($urandom()), $urandom(), 2'($urandom()),
              1'($urandom()), 1'($urandom()), tmo, 1'($urandom()), 1'($urandom()), rand120(),
              kf, ka, 1'($urandom()));
    end
  endtask

  task automatic test_rst_mid();
    cmd_idx_i   = 6'd40;
    cmd_arg_i   = 32'hDEAD_BEEF;
    resp_type_i = 2'b01;
    timeout_i   = 16'd0;
    start_i     = 1'b1;
    @(negedge sd_clk);
    start_i = 1'b0;
    repeat (8) @(negedge sd_clk);
    rst = 1'b1;
    exp_resp = '0;
    @(negedge sd_clk);
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge sd_clk);
      total++;
      if (busy_o !== (k <= 4) || ser_rst_o !== (k <= 4) || done_o !== 1'b0) begin
        bad++; $display("FAIL rst_mid[%0d]: got busy=%b rst=%b done=%b want %b %b 0", k, busy_o,
                        ser_rst_o, done_o, k <= 4, k <= 4);
      end
    end
    total++;
    if (status_o !== 5'b0 || response_o !== exp_resp || ser_cmd_o !== 40'b0) begin
      bad++; $display("FAIL rst_mid_state: got %b/%h/%h want 0/0/0", status_o, response_o,
                      ser_cmd_o);
    end
    run_cmd("after_rst", 6'd1, 32'h7, 2'b01, 1'b1, 1'b1, 16'd0, 1'b1, 1'b1, rand120(), 5, 0,
            1'b0);
  endtask

  initial begin
    test_reset();
    test_no_resp();
    test_short_resp();
    test_long_checks();
    test_timeout();
    test_abort();
    test_hold_start();
    test_random();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
